// File: rtl/io_bank_exerciser.sv
// io_bank_exerciser: bring-up engine for a bank of bidirectional fabric IO cells.
// In PASS mode it registers the user design's pad data and enables. A WALK run
// drives a walking one across the unmasked pins. A READBACK run also samples
// the pads back through synchronisers and counts the steps that mismatch.
module io_bank_exerciser #(
    parameter int NUM_IO      = 31,
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 16,
    parameter int ERR_W       = 16,
    localparam int IDX_W      = (NUM_IO > 1) ? $clog2(NUM_IO) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic [DIV_W-1:0]  div,
    input  logic [NUM_IO-1:0] oeb_mask,
    input  logic [NUM_IO-1:0] user_out,
    input  logic [NUM_IO-1:0] user_oeb,
    input  logic [NUM_IO-1:0] io_in,
    output logic [NUM_IO-1:0] io_out,
    output logic [NUM_IO-1:0] io_oeb,
    output logic [NUM_IO-1:0] sync_in,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_count,
    output logic [IDX_W-1:0]  first_err_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRIVE,
        S_CHECK,
        S_NEXT,
        S_FIN
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } find_t;

    // The dwell must outlast the synchroniser, so the limit (dwell minus one)
    // is never below SYNC_STAGES+1.
    localparam logic [DIV_W-1:0] MIN_LIM = DIV_W'(SYNC_STAGES + 1);

    // Lowest index >= lo whose bit in m is clear.
    function automatic find_t find_clear(input logic [NUM_IO-1:0] m, input int lo);
        find_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = NUM_IO - 1; k >= 0; k--) begin
            if (k >= lo && !m[k]) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(k);
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_IO-1:0] one_hot(input logic [IDX_W-1:0] i);
        return NUM_IO'(1) << i;
    endfunction

    state_t             state, state_nx;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic [DIV_W-1:0]   cnt;
    logic [DIV_W-1:0]   lim_l;
    logic [NUM_IO-1:0]  mask_l;
    logic               rb_l;
    logic               accept;
    logic [NUM_IO-1:0]  out_nx, oeb_nx;
    logic [NUM_IO-1:0]  mism;
    find_t              first_pin, next_pin, first_mism;

    logic [NUM_IO-1:0]  sync_q [SYNC_STAGES];

    // Per-bit synchroniser chain on the pad inputs, active in every mode.
    // NOTE: the chain array is reset too, so sync_in is 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= io_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    // Next-state, step index and next pad values for the sweep FSM.
    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        accept     = 1'b0;
        out_nx     = '0;
        oeb_nx     = '1;
        first_pin  = find_clear(mask_l, 0);
        next_pin   = find_clear(mask_l, int'(idx) + 1);
        mism       = (sync_in ^ one_hot(idx)) & ~mask_l;
        first_mism = find_clear(~mism, 0);

        case (state)
            S_IDLE: begin
                if (start && (mode == 2'd1 || mode == 2'd2)) begin
                    accept   = 1'b1;
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                if (first_pin.found) begin
                    idx_nx   = first_pin.idx;
                    state_nx = S_DRIVE;
                end else begin
                    state_nx = S_FIN;
                end
            end
            S_DRIVE: begin
                if (cnt == lim_l) state_nx = rb_l ? S_CHECK : S_NEXT;
            end
            S_CHECK: state_nx = S_NEXT;
            S_NEXT: begin
                if (next_pin.found) begin
                    idx_nx   = next_pin.idx;
                    state_nx = S_DRIVE;
                end else begin
                    state_nx = S_FIN;
                end
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        // Pads are registered from the state being entered, so they change
        // exactly on the state boundary.
        if (state == S_IDLE && !accept) begin
            out_nx = user_out;
            oeb_nx = user_oeb;
        end else if (state_nx == S_DRIVE) begin
            out_nx = one_hot(idx_nx);
            oeb_nx = mask_l;
        end else if (state_nx == S_CHECK || state_nx == S_NEXT) begin
            oeb_nx = mask_l;
        end
    end

    // State, run configuration, pad registers and readback results.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            cnt           <= '0;
            lim_l         <= MIN_LIM;
            mask_l        <= '1;
            rb_l          <= 1'b0;
            io_out        <= '0;
            io_oeb        <= '1;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '1;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            io_out <= out_nx;
            io_oeb <= oeb_nx;
            done   <= (state == S_FIN);

            if (state == S_DRIVE && cnt != lim_l) cnt <= cnt + 1'b1;
            else                                  cnt <= '0;

            if (accept) begin
                rb_l          <= (mode == 2'd2);
                mask_l        <= oeb_mask;
                lim_l         <= (div > MIN_LIM) ? div : MIN_LIM;
                busy          <= 1'b1;
                err_count     <= '0;
                first_err_idx <= '1;
            end else if (state == S_FIN) begin
                busy <= 1'b0;
            end

            // One error per failing step, however many pins disagree.
            if (state == S_CHECK && first_mism.found) begin
                if (err_count != '1)     err_count     <= err_count + 1'b1;
                if (first_err_idx == '1) first_err_idx <= first_mism.idx;
            end
        end
    end

endmodule

// File: tb/tb_io_bank_exerciser.sv
// Self-checking bench for io_bank_exerciser: per-cycle trace of every sweep
// against a reference built from the pin list, plus readback result checks.
module tb_io_bank_exerciser;

    localparam int N    = 31;
    localparam int S    = 2;
    localparam int NONE = 31;

    typedef logic [N-1:0] vec_t;
    typedef struct {
        vec_t o;
        vec_t t;
        bit   b;
        bit   d;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        start;
    logic [15:0] div;
    vec_t        oeb_mask, user_out, user_oeb;
    vec_t        io_in, io_out, io_oeb, sync_in;
    logic        busy, done;
    logic [15:0] err_count;
    logic [4:0]  first_err_idx;

    vec_t        s_io_in, s_io_out, s_io_oeb, s_sync_in;
    logic        s_busy, s_done;
    logic [1:0]  s_err;
    logic [4:0]  s_first;

    vec_t stuck0 = '0;
    vec_t stuck1 = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Pad model: loopback with optional stuck-at faults.
    always_comb io_in = (io_out & ~stuck0) | stuck1;
    assign s_io_in = '0;

    io_bank_exerciser #(.NUM_IO(N), .SYNC_STAGES(S), .DIV_W(16), .ERR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .start(start), .div(div),
        .oeb_mask(oeb_mask), .user_out(user_out), .user_oeb(user_oeb),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .sync_in(sync_in),
        .busy(busy), .done(done), .err_count(err_count), .first_err_idx(first_err_idx)
    );

    io_bank_exerciser #(.NUM_IO(N), .SYNC_STAGES(S), .DIV_W(16), .ERR_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .mode(mode), .start(start), .div(div),
        .oeb_mask(oeb_mask), .user_out(user_out), .user_oeb(user_oeb),
        .io_in(s_io_in), .io_out(s_io_out), .io_oeb(s_io_oeb), .sync_in(s_sync_in),
        .busy(s_busy), .done(s_done), .err_count(s_err), .first_err_idx(s_first)
    );

    function automatic cyc_t mk(input vec_t o, input vec_t t, input bit b, input bit d);
        cyc_t c;
        c.o = o;
        c.t = t;
        c.b = b;
        c.d = d;
        return c;
    endfunction

    // Readback outcome: each unmasked pin p in turn is the only pin driven high;
    // a step fails if any unmasked pad reads differently.
    function automatic void model_rb(input vec_t msk, input vec_t s0, input vec_t s1,
                                     input int sat, output int errs, output int first);
        vec_t oh, rd, mm;
        errs  = 0;
        first = -1;
        for (int p = 0; p < N; p++) begin
            if (!msk[p]) begin
                oh = vec_t'(1) << p;
                rd = (oh & ~s0) | s1;
                mm = (rd ^ oh) & ~msk;
                if (mm != '0) begin
                    if (errs < sat) errs++;
                    for (int k = 0; k < N; k++)
                        if (mm[k] && first < 0) first = k;
                end
            end
        end
        if (first < 0) first = NONE;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        mode = 2'd1; start = 1'b1; div = 16'd0; oeb_mask = '0;
        user_out = '1; user_oeb = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({io_out, io_oeb, sync_in, busy, done} !== {vec_t'(0), vec_t'('1), vec_t'(0), 2'b00}) begin
            errors++;
            $display("FAIL reset_pads: got out=%h oeb=%h sync=%h busy=%b done=%b", io_out, io_oeb, sync_in, busy, done);
        end
        checks++;
        if ({err_count, first_err_idx, s_err, s_first} !== {16'd0, 5'd31, 2'd0, 5'd31}) begin
            errors++;
            $display("FAIL reset_results: got err=%0d first=%0d sat_err=%0d sat_first=%0d, want 0 31 0 31",
                     err_count, first_err_idx, s_err, s_first);
        end
        rst_n = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        @(negedge clk);
    endtask

    task automatic test_pass();
        vec_t a, b;
        for (int n = 0; n < 8; n++) begin
            mode  = (n % 2 == 0) ? 2'd0 : 2'd3;
            start = 1'b1;
            if (n == 0)      begin user_out = 31'h2AAAAAAA; user_oeb = '0; end
            else if (n == 1) begin user_out = 31'h2AAAAAAA; user_oeb = '1; end
            else             begin user_out = vec_t'($urandom); user_oeb = vec_t'($urandom); end
            @(negedge clk);
            checks++;
            if ({io_out, io_oeb, busy} !== {user_out, user_oeb, 1'b0}) begin
                errors++;
                $display("FAIL pass_%0d: got out=%h oeb=%h busy=%b, want out=%h oeb=%h busy=0",
                         n, io_out, io_oeb, busy, user_out, user_oeb);
            end
        end
        start = 1'b0;
        // Synchroniser latency: old value seen S cycles after the change, new one after S+1.
        a = vec_t'($urandom);
        b = ~a;
        mode = 2'd0; user_oeb = '0; user_out = a;
        repeat (5) @(negedge clk);
        user_out = b;
        repeat (S) @(negedge clk);
        checks++;
        if (sync_in !== a) begin
            errors++;
            $display("FAIL sync_early: got %h want %h", sync_in, a);
        end
        @(negedge clk);
        checks++;
        if (sync_in !== b) begin
            errors++;
            $display("FAIL sync_latency: got %h want %h", sync_in, b);
        end
    endtask

    // One complete run compared cycle by cycle, then the readback results.
    task automatic do_run(input string name, input logic [1:0] md, input logic [15:0] dv,
                          input vec_t msk, input bit disturb);
        cyc_t exp_q[$];
        cyc_t c;
        vec_t oh;
        int   d, e_err, e_first, x_err, x_first;
        bit   rb;
        rb = (md == 2'd2);
        d  = (int'(dv) + 1 > S + 2) ? int'(dv) + 1 : S + 2;
        exp_q.push_back(mk('0, '1, 1'b1, 1'b0));
        for (int p = 0; p < N; p++) begin
            if (!msk[p]) begin
                oh = vec_t'(1) << p;
                repeat (d) exp_q.push_back(mk(oh, msk, 1'b1, 1'b0));
                if (rb) exp_q.push_back(mk('0, msk, 1'b1, 1'b0));
                exp_q.push_back(mk('0, msk, 1'b1, 1'b0));
            end
        end
        exp_q.push_back(mk('0, '1, 1'b1, 1'b0));
        exp_q.push_back(mk('0, '1, 1'b0, 1'b1));
        if (rb) begin
            model_rb(msk, stuck0, stuck1, 65535, e_err, e_first);
            model_rb(msk, '1, '0, 3, x_err, x_first);
        end else begin
            e_err = 0; e_first = NONE; x_err = 0; x_first = NONE;
        end

        mode = md; div = dv; oeb_mask = msk; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (j > 0) @(negedge clk);
            c = exp_q[j];
            checks++;
            if ({io_out, io_oeb, busy, done} !== {c.o, c.t, c.b, c.d}) begin
                errors++;
                $display("FAIL %s cycle %0d: got out=%h oeb=%h busy=%b done=%b, want out=%h oeb=%h busy=%b done=%b",
                         name, j, io_out, io_oeb, busy, done, c.o, c.t, c.b, c.d);
            end
            user_out = vec_t'($urandom);
            user_oeb = vec_t'($urandom);
            if (disturb && j == 20) begin
                start = 1'b1; mode = rb ? 2'd1 : 2'd2; div = 16'd0; oeb_mask = ~msk;
            end
            if (disturb && j == 21) begin
                start = 1'b0; mode = 2'd0;
            end
        end
        mode = 2'd0;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL %s after_done: got busy=%b done=%b, want 0 0", name, busy, done);
        end
        checks++;
        if (err_count !== 16'(e_err) || first_err_idx !== 5'(e_first)) begin
            errors++;
            $display("FAIL %s result: got err=%0d first=%0d, want err=%0d first=%0d",
                     name, err_count, first_err_idx, e_err, e_first);
        end
        checks++;
        if (s_err !== 2'(x_err) || s_first !== 5'(x_first)) begin
            errors++;
            $display("FAIL %s sat_result: got err=%0d first=%0d, want err=%0d first=%0d",
                     name, s_err, s_first, x_err, x_first);
        end
    endtask

    task automatic test_walk();
        stuck0 = '0; stuck1 = '0;
        do_run("walk", 2'd1, 16'd7, '0, 1'b1);
    endtask

    task automatic test_readback_loop();
        stuck0 = '0; stuck1 = '0;
        do_run("rb_loop", 2'd2, 16'd0, 31'h0000FFFF, 1'b1);
        checks++;
        if (err_count !== 16'd0 || first_err_idx !== 5'd31) begin
            errors++;
            $display("FAIL rb_loop_clean: got err=%0d first=%0d, want 0 31", err_count, first_err_idx);
        end
    endtask

    task automatic test_readback_stuck();
        stuck0 = vec_t'(1) << 20;
        stuck1 = vec_t'(1) << 25;
        do_run("rb_stuck", 2'd2, 16'd2, '0, 1'b0);
        stuck0 = '0; stuck1 = '0;
    endtask

    task automatic test_zero_pin();
        do_run("zero_pin", 2'd2, 16'($urandom_range(0, 9)), '1, 1'b0);
    endtask

    task automatic test_saturation();
        do_run("saturate", 2'd2, 16'd0, '0, 1'b0);
        checks++;
        if (s_err !== 2'd3 || s_first !== 5'd0) begin
            errors++;
            $display("FAIL saturate_hold: got err=%0d first=%0d, want 3 0", s_err, s_first);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            stuck0 = vec_t'($urandom & $urandom & $urandom);
            stuck1 = vec_t'($urandom & $urandom & $urandom);
            do_run($sformatf("rand%0d", r), 2'($urandom_range(1, 2)), 16'($urandom_range(0, 6)),
                   vec_t'($urandom & $urandom), 1'b0);
        end
        stuck0 = '0; stuck1 = '0;
    endtask

    task automatic test_mid_reset();
        bit   hit = 1'b0;
        vec_t want = vec_t'(1) << 10;
        mode = 2'd2; div = 16'd3; oeb_mask = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 400 && !hit; j++) begin
            @(negedge clk);
            if (io_out === want) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL mid_reset_reach: got out=%h, want %h within 400 cycles", io_out, want);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({io_out, io_oeb, sync_in, busy, done, err_count, first_err_idx} !==
            {vec_t'(0), vec_t'('1), vec_t'(0), 2'b00, 16'd0, 5'd31}) begin
            errors++;
            $display("FAIL mid_reset_values: got out=%h oeb=%h sync=%h busy=%b done=%b err=%0d first=%0d",
                     io_out, io_oeb, sync_in, busy, done, err_count, first_err_idx);
        end
        checks++;
        if ({s_busy, s_err, s_first} !== {1'b0, 2'd0, 5'd31}) begin
            errors++;
            $display("FAIL mid_reset_sat: got busy=%b err=%0d first=%0d, want 0 0 31", s_busy, s_err, s_first);
        end
        mode = 2'd0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j == 3) rst_n = 1'b1;
            checks++;
            if ({busy, done} !== 2'b00) begin
                errors++;
                $display("FAIL mid_reset_no_done %0d: got busy=%b done=%b, want 0 0", j, busy, done);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pass();
        test_walk();
        test_readback_loop();
        test_readback_stuck();
        test_zero_pin();
        test_saturation();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
